input_entry_ctrl: RTL and testbench

//  Front-end input stage feeding the uP's Enter/Input pair.
//  - Synchronises and debounces the raw Enter push-button.
//  - On each debounced press, captures the 8-bit switch word into a small FIFO.
//  - Replays queued words to the uP as a stable Input byte plus a fixed-width

---
 rtl/input_entry_ctrl.sv | 135 +++++++++++++
 tb/tb_input_entry_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_entry_ctrl.sv
// Enter-button front end: synchroniser, debouncer, word FIFO and Enter pulser.
// Optional DROP_OLDEST_EN: a push while full overwrites the oldest queued word.
module input_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int ENTER_WIDTH     = 2,
    parameter int GAP_CYCLES      = 8
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        BtnRaw,
    input  logic [7:0]                  SwIn,
    input  logic                        Halt,
    input  logic                        ClrOvf,
    output logic [7:0]                  Input,
    output logic                        Enter,
    output logic [$clog2(FIFO_DEPTH):0] Count,
    output logic                        Overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (ENTER_WIDTH > GAP_CYCLES) ? ENTER_WIDTH : GAP_CYCLES;
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    logic          sync1, sync2;
    logic          deb, deb_d;
    logic [DW-1:0] deb_cnt;
    logic          press;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, drop, wr_en, rd_adv;
    state_t        state, next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic          enter_next;
    logic [7:0]    input_next;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= BtnRaw;
            sync2 <= sync1;
        end
    end

    // Debounced level flips only after a full run of disagreeing samples.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            deb_d <= deb;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb     <= ~deb;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press = deb & ~deb_d;
    assign Count = wr_ptr - rd_ptr;
    assign full  = (Count == CW'(FIFO_DEPTH));
    assign drop  = press & full & ~pop;

`ifdef DROP_OLDEST_EN
    assign wr_en  = press;
    assign rd_adv = pop | drop;
`else
    assign wr_en  = press & ~drop;
    assign rd_adv = pop;
`endif

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLOCK) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= SwIn;
    end

    // FIFO pointers and sticky overflow flag (a new set beats a clear).
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + CW'(wr_en);
            rd_ptr <= rd_ptr + CW'(rd_adv);
            if (drop)        Overflow <= 1'b1;
            else if (ClrOvf) Overflow <= 1'b0;
        end
    end

    // Delivery FSM state register with registered Enter and Input.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            tcnt  <= '0;
            Enter <= 1'b0;
            Input <= 8'h00;
        end else begin
            state <= next;
            tcnt  <= tcnt_next;
            Enter <= enter_next;
            Input <= input_next;
        end
    end

    // Next-state logic; Halt matters only while idle.
    always_comb begin
        next = state;
        case (state)
            IDLE:  if (Count != '0 && !Halt)           next = PULSE;
            PULSE: if (tcnt == TW'(ENTER_WIDTH - 1))   next = GAP;
            GAP:   if (tcnt == TW'(GAP_CYCLES - 1))    next = IDLE;
            default:                                    next = IDLE;
        endcase
    end

    // Outputs: pop on entering PULSE, phase timer restarts on each transition.
    always_comb begin
        pop        = (state == IDLE) && (next == PULSE);
        enter_next = (next == PULSE);
        tcnt_next  = (next != state) ? '0 : tcnt + 1'b1;
        input_next = pop ? mem[rd_ptr[AW-1:0]] : Input;
    end
endmodule

// File: tb/tb_input_entry_ctrl.sv
// Scoreboard bench for input_entry_ctrl.
// Honours DROP_OLDEST_EN for the overflow expectations.
module tb_input_entry_ctrl;
    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       BtnRaw;
    logic [7:0] SwIn;
    logic       Halt;
    logic       ClrOvf;
    logic [7:0] Input;
    logic       Enter;
    logic [2:0] Count;
    logic       Overflow;

    int checks = 0;
    int errors = 0;
    int npulse = 0;
    int peak = 0;
    int hi = 0;
    int lo = 0;
    int seen = 0;
    logic prev = 1'b0;
    logic [7:0] sb [$];

    input_entry_ctrl dut (
        .CLOCK(CLOCK), .RESET(RESET), .BtnRaw(BtnRaw), .SwIn(SwIn),
        .Halt(Halt), .ClrOvf(ClrOvf), .Input(Input), .Enter(Enter),
        .Count(Count), .Overflow(Overflow)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (RESET) begin
            prev = 1'b0;
            hi = 0;
            lo = 0;
            seen = 0;
        end else begin
            if (Enter && !prev) begin
                if (seen != 0) check("gap", int'(lo >= 8), 1);
                if (sb.size() == 0) check("unexp_enter", 1, 0);
                else check("input", Input, sb.pop_front());
                npulse++;
                hi = 1;
            end else if (Enter) begin
                hi++;
            end else if (prev) begin
                check("width", hi, 2);
                lo = 1;
                seen = 1;
            end else begin
                lo++;
            end
            prev = Enter;
            if (int'(Count) > peak) peak = int'(Count);
        end
    end

    task automatic press(input logic [7:0] w, input int h, input int l);
        @(posedge CLOCK); #1;
        SwIn = w;
        BtnRaw = 1'b1;
        repeat (h) @(posedge CLOCK);
        #1 BtnRaw = 1'b0;
        repeat (l) @(posedge CLOCK);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(posedge CLOCK);
            if (sb.size() == 0) break;
        end
        check("drain_timeout", int'(i < 2000), 1);
        repeat (12) @(posedge CLOCK);
    endtask

    initial begin
        int n0;
        int lat;
        RESET = 1'b1;
        BtnRaw = 1'b0;
        SwIn = 8'h00;
        Halt = 1'b0;
        ClrOvf = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLOCK); #1 BtnRaw = ~BtnRaw;
        end
        check("rst_input", Input, 8'h00);
        check("rst_enter", Enter, 0);
        check("rst_count", Count, 0);
        check("rst_ovf", Overflow, 0);
        BtnRaw = 1'b0;
        @(posedge CLOCK); #1 RESET = 1'b0;
        repeat (10) @(posedge CLOCK);

        // bounce: glitches must not produce a pulse
        SwIn = 8'hA5;
        n0 = npulse;
        for (int k = 1; k <= 3; k++) press(8'hA5, k, 6);
        repeat (10) @(posedge CLOCK);
        check("bounce_none", npulse, n0);
        check("bounce_count", Count, 0);
        sb.push_back(8'hA5);
        @(posedge CLOCK); #1 BtnRaw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLOCK); #1;
            if (Enter) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 8);
        check("lat_input", Input, 8'hA5);
        repeat (2) @(posedge CLOCK);
        #1 BtnRaw = 1'b0;
        drain();
        check("bounce_one", npulse, n0 + 1);

        // burst
        peak = 0;
        n0 = npulse;
        sb.push_back(8'h3C);
        sb.push_back(8'h7E);
        sb.push_back(8'h01);
        press(8'h3C, 6, 6);
        press(8'h7E, 6, 6);
        press(8'h01, 6, 6);
        drain();
        check("burst_pulses", npulse, n0 + 3);
        check("burst_peak", int'(peak >= 1 && peak <= 2), 1);

        // halt
        n0 = npulse;
        Halt = 1'b1;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        press(8'h11, 10, 10);
        press(8'h22, 10, 10);
        check("halt_count", Count, 2);
        check("halt_enter", npulse, n0);
        #1 Halt = 1'b0;
        drain();
        check("halt_count0", Count, 0);

        // overflow
        Halt = 1'b1;
`ifdef DROP_OLDEST_EN
        for (int i = 2; i <= 5; i++) sb.push_back(8'(i));
`else
        for (int i = 1; i <= 4; i++) sb.push_back(8'(i));
`endif
        for (int i = 1; i <= 5; i++) press(8'(i), 10, 10);
        check("ovf_count", Count, 4);
        check("ovf_flag", Overflow, 1);
        #1 Halt = 1'b0;
        drain();
        check("ovf_sticky", Overflow, 1);
        @(posedge CLOCK); #1 ClrOvf = 1'b1;
        @(posedge CLOCK); #1 ClrOvf = 1'b0;
        check("ovf_clr", Overflow, 0);

        // full push with simultaneous pop
        Halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'h41 + 8'(i));
            press(8'h41 + 8'(i), 10, 10);
        end
        check("full_count", Count, 4);
        sb.push_back(8'h45);
        @(posedge CLOCK); #1;
        SwIn = 8'h45;
        BtnRaw = 1'b1;
        repeat (6) @(posedge CLOCK);
        #1 Halt = 1'b0;
        @(posedge CLOCK); #1;
        check("pp_count", Count, 4);
        check("pp_ovf", Overflow, 0);
        repeat (3) @(posedge CLOCK);
        #1 BtnRaw = 1'b0;
        drain();
        check("pp_ovf_end", Overflow, 0);

        // reset mid-pulse
        sb.push_back(8'h5A);
        @(posedge CLOCK); #1;
        SwIn = 8'h5A;
        BtnRaw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLOCK); #1;
            if (Enter) begin
                lat = i;
                break;
            end
        end
        check("mid_seen", int'(lat != 0), 1);
        RESET = 1'b1;
        #1;
        check("mid_enter", Enter, 0);
        check("mid_count", Count, 0);
        check("mid_input", Input, 8'h00);
        sb.delete();
        BtnRaw = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;
        repeat (10) @(posedge CLOCK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
